// File: rtl/mux_cfg_pkg.sv
// Shared types and constants for the mux configuration loader.
// Optional parity checking is enabled by defining MUX_CFG_LOADER_PARITY_EN.
package mux_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Bit positions of the mux stage inputs within cfg_out
    localparam int CFG_SEL_LO  = 0;
    localparam int CFG_D0      = 1;
    localparam int CFG_D1      = 2;
    localparam int CFG_D2      = 3;
    localparam int CFG_D3      = 4;
    localparam int CFG_BYP_D   = 5;
    localparam int CFG_SEL_HI  = 6;
    localparam int CFG_BYP_SEL = 7;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 15;

`ifdef MUX_CFG_LOADER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/mux_cfg_shreg.sv
// Shadow shift register (MSB first) plus per-frame bit counter.
// Bits beyond WIDTH (the parity bit) are counted but never shifted into the shadow word.
module mux_cfg_shreg
    import mux_cfg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NBITS = DEF_WIDTH,
    parameter int CW    = $clog2(DEF_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] shadow,
    output logic             done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            count  <= '0;
        end else if (clear) begin
            shadow <= '0;
            count  <= '0;
        end else if (shift) begin
            if (count < CW'(WIDTH)) begin
                shadow <= {shadow[WIDTH-2:0], din};
            end
            count <= count + CW'(1);
        end
    end

    // High while the bit being accepted this cycle is the last of the frame
    assign done = (count == CW'(NBITS - 1));

endmodule

// File: rtl/mux_cfg_loader.sv
// Serial-to-parallel loader that commits a whole configuration word to the mux stage at once.
// Define MUX_CFG_LOADER_PARITY_EN to require a trailing even-parity bit on every frame.
module mux_cfg_loader
    import mux_cfg_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic [WIDTH-1:0] cfg_out,
    output logic             cfg_valid,
    output logic             busy,
    output logic             err
);

    localparam int CW    = $clog2(WIDTH + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int NBITS = WIDTH + PARITY_BITS;

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] shadow;
    logic             sh_done;
    logic             sh_clear;
    logic             sh_shift;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             err_set;
    logic             err_clr;
    logic             commit;

    mux_cfg_shreg #(
        .WIDTH (WIDTH),
        .NBITS (NBITS),
        .CW    (CW)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (sh_clear),
        .shift  (sh_shift),
        .din    (ser_in),
        .shadow (shadow),
        .done   (sh_done)
    );

`ifdef MUX_CFG_LOADER_PARITY_EN
    logic par_ok;
    assign par_ok = ((^shadow) == ser_in);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sh_clear  = 1'b0;
        sh_shift  = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (frame) begin
                    state_nxt = SHIFT;
                    sh_clear  = 1'b1;
                    tmr_clr   = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            SHIFT: begin
                // A new frame pulse wins over a coincident data bit, which is dropped
                if (frame) begin
                    sh_clear = 1'b1;
                    tmr_clr  = 1'b1;
                end else if (ser_valid) begin
                    sh_shift = 1'b1;
                    tmr_clr  = 1'b1;
                    if (sh_done) begin
`ifdef MUX_CFG_LOADER_PARITY_EN
                        if (par_ok) begin
                            state_nxt = COMMIT;
                        end else begin
                            state_nxt = IDLE;
                            err_set   = 1'b1;
                        end
`else
                        state_nxt = COMMIT;
`endif
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                    tmr_clr   = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            COMMIT: begin
                commit = 1'b1;
                if (frame) begin
                    state_nxt = SHIFT;
                    sh_clear  = 1'b1;
                    tmr_clr   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tmr_clr) begin
            timer <= '0;
        end else if (tmr_inc) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // cfg_out and cfg_valid move together so the mux only ever sees whole words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
        end else begin
            cfg_valid <= commit;
            if (commit) begin
                cfg_out <= shadow;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mux_cfg_loader.md
Name: mux_cfg_loader

Overview:
- Serial-to-parallel configuration loader placed directly upstream of the 4:1 mux-with-bypass stage.
- Receives an 8-bit configuration word over a 3-wire serial link: strobe, data and frame.
- Presents the word as a stable parallel bus in the mux stage's input bit order:
  - bit0 = sel_lo, bits[4:1] = d0..d3, bit5 = bypass data, bit6 = sel_hi, bit7 = bypass select.
- The bus changes only on a complete, valid frame, so the mux never sees partial words.

Parameters:
- WIDTH, 8, configuration word width in bits; the bit counter is sized $clog2(WIDTH+1).
- TIMEOUT, 15, maximum idle cycles between ser_valid strobes inside a frame before the frame is aborted; the counter is sized to TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- frame  input  1  one-cycle start-of-frame pulse.
- ser_valid  input  1  qualifies ser_in for one bit.
- ser_in  input  1  serial data, MSB first.
- cfg_out  output  WIDTH  committed configuration word that drives the mux stage.
- cfg_valid  output  1  one-cycle pulse on the cycle cfg_out updates.
- busy  output  1  high while a frame is in progress.
- err  output  1  sticky error flag; cleared by the next frame pulse or by reset.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; the clock and reset ports are named clk and rst_n.
- Reset values:
  - cfg_out = 0, cfg_valid = 0, busy = 0, err = 0.
  - Internal: state = IDLE, shadow = 0, bit count = 0, idle timer = 0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - ser_valid is ignored.
  - frame=1 -> SHIFT; shadow <= 0, count <= 0, timer <= 0, err <= 0.
- SHIFT (busy=1):
  - ser_valid=1: shadow <= {shadow[WIDTH-2:0], ser_in}; count++; timer <= 0.
  - When count reaches WIDTH-1 together with ser_valid=1 -> COMMIT.
  - ser_valid=0: timer++. If timer == TIMEOUT -> IDLE with err <= 1; cfg_out is unchanged.
  - frame=1 in SHIFT restarts the frame (shadow, count and timer cleared; stay in SHIFT; err unchanged). frame takes priority over a simultaneous ser_valid, and that bit is discarded.
- COMMIT (one cycle, busy=1):
  - cfg_out <= shadow registered; cfg_valid=1 on the following cycle, aligned with the new cfg_out.
  - -> IDLE.
  - frame=1 during COMMIT: the commit still completes, then the FSM goes directly to SHIFT with counters cleared (back-to-back frames).
- Latency: cfg_out updates 2 cycles after the final ser_valid bit.
- cfg_out is held indefinitely between commits.
- Reset mid-frame discards the partial word; cfg_out returns to 0.

Optional Feature:
- Macro: MUX_CFG_LOADER_PARITY_EN.
- When defined:
  - A 9th serial bit follows the data and carries even parity over the WIDTH data bits.
  - Count runs to WIDTH. A parity mismatch -> IDLE with err=1; no commit, cfg_valid stays 0, cfg_out unchanged.
  - The timeout also applies to the parity bit.
- When undefined: exactly WIDTH bits per frame; no parity check.

Decomposition:
- Shared package mux_cfg_pkg:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - Bit-position constants for cfg_out: CFG_SEL_LO=0, CFG_D0=1 .. CFG_D3=4, CFG_BYP_D=5, CFG_SEL_HI=6, CFG_BYP_SEL=7.
  - Default WIDTH and TIMEOUT.
- One sub-module, mux_cfg_shreg: shadow shift register plus bit counter, with shift/clear/done signals.
- FSM, timer and output register stay in the top level.

Test Plan:
- Reset, then frame followed by ser_in bits 1,0,1,1,0,0,1,0 on consecutive ser_valid cycles -> cfg_out=8'hB2 two cycles after the last bit, cfg_valid high for exactly 1 cycle, busy low afterwards.
- Send frame A5, then 3 bits, then frame again, then 8 bits of 3C -> cfg_out=8'h3C, one cfg_valid pulse, no intermediate update, err=0.
- Send frame plus 4 bits, then hold ser_valid low for 15 cycles -> err=1, busy=0, cfg_out keeps its previous value (0 after reset); the next frame clears err.
- Send 8'hFF, then frame asserted on the COMMIT cycle, followed by 8'h01 -> two cfg_valid pulses, cfg_out sequence FF then 01, no lost bit.
- Assert rst_n low mid-frame after 5 bits -> all outputs 0 immediately (asynchronous); a subsequent full frame of 8'h81 gives cfg_out=8'h81.
- With MUX_CFG_LOADER_PARITY_EN defined: send 8'h03 with parity bit 0 -> commit. Send 8'h03 with parity bit 1 -> err=1, cfg_out unchanged, no cfg_valid.
